// File: rtl/dma_mem_responder_pkg.sv
// dma_mc_defs: shared definitions for the memory-controller end of the
// core-control protocol (FSM state encodings and condition codes seen on
// ctrl_data_contition).
package dma_mc_defs;

  typedef enum logic [2:0] {
    M_IDLE  = 3'd0,
    M_STORE = 3'd1,
    M_RD_A  = 3'd2,
    M_RD_B  = 3'd3,
    M_RD_C  = 3'd4,
    M_READY = 3'd5,
    M_PROC  = 3'd6
  } mc_state_t;

  // Condition bits: [HAS_DATA | VALID_DATA | HAS_DATA_R | VALID_DATA_R]
  localparam logic [3:0] COND_IDLE  = 4'b0000;
  localparam logic [3:0] COND_TRANS = 4'b1100;
  localparam logic [3:0] COND_PROC  = 4'b1111;
  localparam logic [3:0] COND_DONE  = 4'b1110;

endpackage

// File: rtl/dma_sp_ram.sv
// dma_sp_ram: DEPTH x DATA_W simple dual-port RAM, one write port and one
// synchronous read port (read data valid the cycle after re).
// Ports:
//   ctrl_clk  clock
//   we/waddr/wdata  write port
//   re/raddr        read request; rdata holds its value until the next re
//   rdata           registered read data
module dma_sp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              ctrl_clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge ctrl_clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dma_mem_responder.sv
// dma_mem_responder: memory-controller end of the core-control protocol.
// Stores an incoming word stream into a local RAM starting at a base
// address, then hands operand pairs (opa, opb) to the processing unit,
// handshaking through mc_cont_procc / mc_data_done / mc_err.
// Ports:
//   ctrl_clk, ctrl_reset (async, active-high)
//   mc_we, ctrl_data_address_out, ctrl_data_contition, data_in, data_in_valid
//   mc_err, mc_cont_procc, mc_data_done, opa, opb, opnd_valid, words_stored
//
// state   | meaning
// M_IDLE  | waiting for mc_we to open a new stream
// M_STORE | writing stream words into RAM until condition 1100
// M_RD_A  | read issued for first operand
// M_RD_B  | capture opa, read issued for second operand if one remains
// M_RD_C  | capture opb (0 on odd tail), raise opnd_valid/mc_cont_procc
// M_READY | pair loaded, waiting for condition 1111
// M_PROC  | processing; on 1110 fetch next pair or finish
module dma_mem_responder
  import dma_mc_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              ctrl_clk,
  input  logic              ctrl_reset,
  input  logic              mc_we,
  input  logic [ADDR_W-1:0] ctrl_data_address_out,
  input  logic [3:0]        ctrl_data_contition,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic              mc_err,
  output logic              mc_cont_procc,
  output logic              mc_data_done,
  output logic [DATA_W-1:0] opa,
  output logic [DATA_W-1:0] opb,
  output logic              opnd_valid,
  output logic [ADDR_W:0]   words_stored
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(2**ADDR_W);

  mc_state_t         state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   stored_q, stored_d, consumed_q, consumed_d, remaining;
  logic [DATA_W-1:0] opa_d, opb_d;
  logic              err_d, cont_d, done_d, valid_d;
  logic              has_b_q, has_b_d;
  logic              ram_we, ram_re, abort;
  logic [DATA_W-1:0] ram_rdata;

  dma_sp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .ctrl_clk (ctrl_clk),
    .we       (ram_we),
    .waddr    (wr_ptr_q),
    .wdata    (data_in),
    .re       (ram_re),
    .raddr    (rd_ptr_q),
    .rdata    (ram_rdata)
  );

  assign remaining    = stored_q - consumed_q;
  assign words_stored = stored_q;
  assign abort = (ctrl_data_contition == COND_IDLE) &&
                 (state_q inside {M_RD_A, M_RD_B, M_RD_C, M_READY, M_PROC});

  always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q       <= M_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      stored_q      <= '0;
      consumed_q    <= '0;
      opa           <= '0;
      opb           <= '0;
      mc_err        <= 1'b0;
      mc_cont_procc <= 1'b0;
      mc_data_done  <= 1'b0;
      opnd_valid    <= 1'b0;
      has_b_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      stored_q      <= stored_d;
      consumed_q    <= consumed_d;
      opa           <= opa_d;
      opb           <= opb_d;
      mc_err        <= err_d;
      mc_cont_procc <= cont_d;
      mc_data_done  <= done_d;
      opnd_valid    <= valid_d;
      has_b_q       <= has_b_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    stored_d   = stored_q;
    consumed_d = consumed_q;
    opa_d      = opa;
    opb_d      = opb;
    err_d      = mc_err;
    cont_d     = mc_cont_procc;
    done_d     = mc_data_done;
    valid_d    = opnd_valid;
    has_b_d    = has_b_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;

    if (abort) begin
      // Abort keeps mc_err / mc_data_done so control can still see why.
      state_d = M_IDLE;
      cont_d  = 1'b0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        M_IDLE: begin
          if (mc_we) begin
            wr_ptr_d   = ctrl_data_address_out;
            rd_ptr_d   = ctrl_data_address_out;
            stored_d   = '0;
            consumed_d = '0;
            err_d      = 1'b0;
            done_d     = 1'b0;
            valid_d    = 1'b0;
            state_d    = M_STORE;
          end
        end
        M_STORE: begin
          // The transfer-end condition wins over a coincident write.
          if (ctrl_data_contition == COND_TRANS) begin
            if (stored_q == '0) begin
              err_d   = 1'b1;
              done_d  = 1'b1;
              state_d = M_IDLE;
            end else begin
              state_d = M_RD_A;
            end
          end else if (mc_we && data_in_valid) begin
            if (stored_q < DEPTH_CNT) begin
              ram_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + 1'b1;
              stored_d = stored_q + 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        M_RD_A: begin
          ram_re     = 1'b1;
          consumed_d = consumed_q + 1'b1;
          rd_ptr_d   = rd_ptr_q + 1'b1;
          state_d    = M_RD_B;
        end
        M_RD_B: begin
          opa_d   = ram_rdata;
          has_b_d = (remaining != '0);
          if (remaining != '0) begin
            ram_re     = 1'b1;
            consumed_d = consumed_q + 1'b1;
            rd_ptr_d   = rd_ptr_q + 1'b1;
          end
          state_d = M_RD_C;
        end
        M_RD_C: begin
          opb_d   = has_b_q ? ram_rdata : '0;
          valid_d = 1'b1;
          cont_d  = 1'b1;
          state_d = M_READY;
        end
        M_READY: begin
          cont_d = 1'b1;
          if (ctrl_data_contition == COND_PROC) state_d = M_PROC;
        end
        M_PROC: begin
          cont_d = (remaining != '0);
          done_d = (remaining == '0);
          if (ctrl_data_contition == COND_DONE) begin
            cont_d = 1'b0;
            if (remaining != '0) begin
              valid_d = 1'b0;
              state_d = M_RD_A;
            end else begin
              done_d  = 1'b1;
              state_d = M_IDLE;
            end
          end
        end
        default: state_d = M_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_mem_responder.sv
module tb_dma_mem_responder;

  logic        ctrl_clk = 1'b0;
  logic        ctrl_reset;
  logic        mc_we;
  logic [5:0]  ctrl_data_address_out;
  logic [3:0]  ctrl_data_contition;
  logic [31:0] data_in;
  logic        data_in_valid;
  logic        mc_err, mc_cont_procc, mc_data_done, opnd_valid;
  logic [31:0] opa, opb;
  logic [6:0]  words_stored;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] wbuf [70];

  dma_mem_responder #(.DATA_W(32), .ADDR_W(6)) dut (
    .ctrl_clk              (ctrl_clk),
    .ctrl_reset            (ctrl_reset),
    .mc_we                 (mc_we),
    .ctrl_data_address_out (ctrl_data_address_out),
    .ctrl_data_contition   (ctrl_data_contition),
    .data_in               (data_in),
    .data_in_valid         (data_in_valid),
    .mc_err                (mc_err),
    .mc_cont_procc         (mc_cont_procc),
    .mc_data_done          (mc_data_done),
    .opa                   (opa),
    .opb                   (opb),
    .opnd_valid            (opnd_valid),
    .words_stored          (words_stored)
  );

  always #5 ctrl_clk = ~ctrl_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ctrl_clk);
    #1;
  endtask

  task automatic load_stream(input logic [5:0] base, input int n);
    mc_we = 1'b1;
    ctrl_data_address_out = base;
    ctrl_data_contition = 4'b0000;
    tick();
    ctrl_data_contition = 4'b1000;
    for (int i = 0; i < n; i++) begin
      data_in = wbuf[i];
      data_in_valid = 1'b1;
      tick();
    end
    data_in_valid = 1'b0;
    mc_we = 1'b0;
    ctrl_data_contition = 4'b1100;
    tick();
  endtask

  // Entered with the FSM in M_RD_A; leaves it in M_RD_A (more) or M_IDLE.
  task automatic fetch_pair(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                            input logic more);
    tick();
    tick();
    chk({tag, " cont low while fetching"}, mc_cont_procc, 0);
    tick();
    chk({tag, " cont_procc"}, mc_cont_procc, 1);
    chk({tag, " opnd_valid"}, opnd_valid, 1);
    chk({tag, " opa"}, opa, ea);
    chk({tag, " opb"}, opb, eb);
    ctrl_data_contition = 4'b1111;
    tick();
    tick();
    chk({tag, " proc cont_procc"}, mc_cont_procc, more);
    chk({tag, " proc data_done"}, mc_data_done, !more);
    ctrl_data_contition = 4'b1110;
    tick();
    chk({tag, " cont after 1110"}, mc_cont_procc, 0);
    if (more) chk({tag, " opnd_valid dropped"}, opnd_valid, 0);
    else      chk({tag, " done held"}, mc_data_done, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " mc_err"}, mc_err, 0);
    chk({tag, " mc_cont_procc"}, mc_cont_procc, 0);
    chk({tag, " mc_data_done"}, mc_data_done, 0);
    chk({tag, " opa"}, opa, 0);
    chk({tag, " opb"}, opb, 0);
    chk({tag, " opnd_valid"}, opnd_valid, 0);
    chk({tag, " words_stored"}, words_stored, 0);
  endtask

  task automatic run_basic(input string tag);
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    load_stream(6'd10, 4);
    chk({tag, " words_stored"}, words_stored, 4);
    chk({tag, " no err"}, mc_err, 0);
    fetch_pair({tag, " p0"}, 32'd1, 32'd2, 1'b1);
    fetch_pair({tag, " p1"}, 32'd3, 32'd4, 1'b0);
    chk({tag, " final done"}, mc_data_done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    ctrl_reset = 1'b1;
    mc_we = 1'b0;
    ctrl_data_address_out = '0;
    ctrl_data_contition = 4'b0000;
    data_in = '0;
    data_in_valid = 1'b0;
    #12;
    check_all_zero("reset");
    ctrl_reset = 1'b0;
    tick();

    run_basic("basic");

    // Overflow: 65 writes into a 64-word RAM starting at 0.
    for (int i = 0; i < 65; i++) wbuf[i] = 32'(i + 1);
    load_stream(6'd0, 65);
    chk("ovf words_stored", words_stored, 64);
    chk("ovf err", mc_err, 1);
    for (int k = 0; k < 32; k++)
      fetch_pair($sformatf("ovf p%0d", k), 32'(2*k + 1), 32'(2*k + 2), k != 31);
    chk("ovf err sticky", mc_err, 1);

    // Address wrap at the top of the RAM.
    wbuf[0] = 32'hAAAA_0001; wbuf[1] = 32'hBBBB_0002;
    wbuf[2] = 32'hCCCC_0003; wbuf[3] = 32'hDDDD_0004;
    load_stream(6'd62, 4);
    chk("wrap err cleared", mc_err, 0);
    fetch_pair("wrap p0", 32'hAAAA_0001, 32'hBBBB_0002, 1'b1);
    fetch_pair("wrap p1", 32'hCCCC_0003, 32'hDDDD_0004, 1'b0);

    // Odd tail.
    wbuf[0] = 32'd5; wbuf[1] = 32'd6; wbuf[2] = 32'd7;
    load_stream(6'd20, 3);
    chk("odd words_stored", words_stored, 3);
    fetch_pair("odd p0", 32'd5, 32'd6, 1'b1);
    fetch_pair("odd p1", 32'd7, 32'd0, 1'b0);

    // Empty transfer.
    load_stream(6'd5, 0);
    chk("empty err", mc_err, 1);
    chk("empty done", mc_data_done, 1);
    chk("empty cont", mc_cont_procc, 0);
    chk("empty words_stored", words_stored, 0);
    ctrl_data_contition = 4'b0000;
    tick();
    chk("empty cont later", mc_cont_procc, 0);
    chk("empty err sticky", mc_err, 1);

    // Async reset while in M_PROC.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    load_stream(6'd10, 4);
    tick(); tick(); tick();
    ctrl_data_contition = 4'b1111;
    tick(); tick();
    chk("pre-reset cont", mc_cont_procc, 1);
    #2 ctrl_reset = 1'b1;
    #1;
    check_all_zero("async reset");
    #2 ctrl_reset = 1'b0;
    ctrl_data_contition = 4'b0000;
    tick();
    run_basic("after reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
